// File: rtl/bexkat1_sram_resp.sv
// Bus responder for a word-addressed on-chip SRAM with big-endian byte lanes and programmable wait states.
// Optional alignment checking is enabled by defining BEXKAT1_SRAM_ALIGN_CHECK_EN.
module bexkat1_sram_resp #(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_cyc_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_adr_i,
    input  logic [3:0]  bus_sel_i,
    input  logic [31:0] bus_dat_i,
    output logic [31:0] bus_dat_o,
    output logic        bus_ack_o,
    output logic        bus_err_o
);
    // Handshake: bus_cyc_i is held with stable request fields until the single-cycle
    // bus_ack_o (or bus_err_o) pulse; dropping it before then aborts with no side effect.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    typedef struct packed {
        state_t     state;
        logic [3:0] cnt;
    } fsm_t;

    localparam bit         NO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    fsm_t          fsm;
    logic [31:0]   mem [0:(1 << AW) - 1];
    logic [AW-1:0] word_adr;
    logic          access;
    logic          legal;
    logic          unused_adr_bits;

    assign word_adr        = bus_adr_i[AW+1:2];
    assign unused_adr_bits = ^{bus_adr_i[31:AW+2], bus_adr_i[1:0]};

    // The access edge is the one that leaves the last waiting cycle (or IDLE when there are none).
    always_comb begin
        access = 1'b0;
        case (fsm.state)
            ST_IDLE: access = bus_cyc_i && NO_WAIT;
            ST_WAIT: access = bus_cyc_i && (fsm.cnt == 4'd0);
            default: access = 1'b0;
        endcase
    end

`ifdef BEXKAT1_SRAM_ALIGN_CHECK_EN
    always_comb begin
        legal = 1'b0;
        case (bus_sel_i)
            4'b1111: legal = (bus_adr_i[1:0] == 2'b00);
            4'b1100: legal = (bus_adr_i[1:0] == 2'b00);
            4'b0011: legal = (bus_adr_i[1:0] == 2'b10);
            4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end
`else
    assign legal = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i && access && legal && bus_we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (bus_sel_i[i]) mem[word_adr][8*i +: 8] <= bus_dat_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm       <= '{state: ST_IDLE, cnt: 4'd0};
            bus_ack_o <= 1'b0;
            bus_err_o <= 1'b0;
            bus_dat_o <= 32'h0;
        end else begin
            bus_ack_o <= 1'b0;
            bus_err_o <= 1'b0;
            case (fsm.state)
                ST_IDLE: begin
                    if (bus_cyc_i) begin
                        if (NO_WAIT) begin
                            fsm.state <= ST_ACK;
                        end else begin
                            fsm.state <= ST_WAIT;
                            fsm.cnt   <= WS_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!bus_cyc_i) begin
                        fsm.state <= ST_IDLE;
                        fsm.cnt   <= 4'd0;
                    end else if (fsm.cnt != 4'd0) begin
                        fsm.cnt <= fsm.cnt - 4'd1;
                    end else begin
                        fsm.state <= ST_ACK;
                    end
                end
                default: begin
                    fsm.state <= ST_IDLE;
                    fsm.cnt   <= 4'd0;
                end
            endcase
            if (access) begin
                bus_ack_o <= legal;
                bus_err_o <= !legal;
                if (legal && !bus_we_i) bus_dat_o <= mem[word_adr];
            end
        end
    end

endmodule
